// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard unit: forwarding selects, multiply FSM states.
// Also holds the forwarding-select helper used for both E-stage operands.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    localparam logic [3:0] REG_PC = 4'd15;

    // The M-stage result is younger than W, so it wins when both match.
    function automatic fwd_e fwd_sel(
        input logic [3:0] src,
        input logic [3:0] wa_m,
        input logic       we_m,
        input logic [3:0] wa_w,
        input logic       we_w
    );
        fwd_e sel;
        sel = FWD_RF;
        if (src != REG_PC) begin
            if (we_m && (wa_m == src))      sel = FWD_M;
            else if (we_w && (wa_w == src)) sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_mul_seq.sv
// Multi-cycle multiply sequencer: holds the front end for MUL_LAT-1 cycles, then pulses done.
// Zero-latency outputs from registered state; a new multiply is only accepted while idle.
module hazard_unit_mul_seq
    import hazard_unit_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic mul_e_i,
    output logic mul_stall_o,
    output logic mul_busy_o,
    output logic mul_done_o
);

    localparam int CW = $clog2(MUL_LAT);

    mul_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_stall_o = 1'b0;
        mul_busy_o  = 1'b0;
        mul_done_o  = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (mul_e_i) begin
                    state_d     = MUL_BUSY;
                    cnt_d       = CW'(MUL_LAT - 2);
                    mul_stall_o = 1'b1;
                end
            end
            MUL_BUSY: begin
                // MulE is deliberately ignored here: the same instruction is still in E.
                if (cnt_q != '0) begin
                    cnt_d       = cnt_q - CW'(1);
                    mul_stall_o = 1'b1;
                    mul_busy_o  = 1'b1;
                end else begin
                    state_d    = MUL_IDLE;
                    mul_done_o = 1'b1;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use stall, PC-write flushes, multiply hold.
// Combinational controls (no added latency); only the multiply FSM and stall counter are registered.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemToRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MulE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MulBusy,
    output logic             MulDone,
    output logic [CNT_W-1:0] StallCycles
);

    logic             ldr_stall;
    logic             pc_wr_pend;
    logic             mul_stall;
    logic             mul_busy;
    logic             mul_done;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    hazard_unit_mul_seq #(
        .MUL_LAT(MUL_LAT)
    ) u_mul_seq (
        .clk        (clk),
        .reset      (reset),
        .mul_e_i    (MulE),
        .mul_stall_o(mul_stall),
        .mul_busy_o (mul_busy),
        .mul_done_o (mul_done)
    );

    assign ldr_stall  = MemToRegE & ((WA3E == RA1D) | (WA3E == RA2D));
    assign pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        MulBusy   = 1'b0;
        MulDone   = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
            ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
            MulBusy   = mul_busy;
            MulDone   = mul_done;
            if (mul_stall) begin
                // Freeze F/D/E around the multiply and feed bubbles into M.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else begin
                StallF = ldr_stall | pc_wr_pend;
                StallD = ldr_stall;
                FlushD = pc_wr_pend | PCSrcW | BranchTakenE;
                FlushE = ldr_stall | BranchTakenE;
            end
        end
    end

    assign stall_cnt_d = (StallF && (stall_cnt_q != {CNT_W{1'b1}}))
                       ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (MUL_LAT=4/CNT_W=4 and MUL_LAT=2/CNT_W=16) against a behavioural model.
// Directed scenarios first, then randomized cycles.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemToRegE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulE;

    logic [1:0]  a_fa, a_fb, b_fa, b_fb;
    logic        a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_busy, a_done;
    logic        b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_busy, b_done;
    logic [3:0]  a_sc;
    logic [15:0] b_sc;

    typedef struct {
        int fa, fb, sf, sd, se, fd, fe, fm, busy, done, nph;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ph_a  = 0;
    int ph_b  = 0;
    int sc_a  = 0;
    int sc_b  = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MUL_LAT(4), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MulE(MulE),
        .ForwardAE(a_fa), .ForwardBE(a_fb), .StallF(a_sf), .StallD(a_sd), .StallE(a_se),
        .FlushD(a_fd), .FlushE(a_fe), .FlushM(a_fm), .MulBusy(a_busy), .MulDone(a_done),
        .StallCycles(a_sc)
    );

    hazard_unit #(.MUL_LAT(2), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemToRegE(MemToRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MulE(MulE),
        .ForwardAE(b_fa), .ForwardBE(b_fb), .StallF(b_sf), .StallD(b_sd), .StallE(b_se),
        .FlushD(b_fd), .FlushE(b_fe), .FlushM(b_fm), .MulBusy(b_busy), .MulDone(b_done),
        .StallCycles(b_sc)
    );

    always @(negedge clk) begin
        assert (!(MulE && (BranchTakenE || MemToRegE)));
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int fwd_ref(input int src);
        if (src == 15) return 0;
        if (RegWriteM && WA3M == src) return 2;
        if (RegWriteW && WA3W == src) return 1;
        return 0;
    endfunction

    // ph = cycles the multiply has already spent in E; it completes on cycle lat.
    function automatic exp_t model(input int lat, input int ph);
        exp_t e;
        int   mstall, ld, pend;
        e = '{default: 0};
        if (reset) begin
            e.fd = 1; e.fe = 1; e.fm = 1;
            return e;
        end
        e.fa = fwd_ref(int'(RA1E));
        e.fb = fwd_ref(int'(RA2E));
        mstall = 0;
        if (ph == 0) begin
            if (MulE) begin mstall = 1; e.nph = 1; end
        end else if (ph < lat - 1) begin
            mstall = 1; e.busy = 1; e.nph = ph + 1;
        end else begin
            e.done = 1; e.nph = 0;
        end
        ld   = (MemToRegE && (WA3E == RA1D || WA3E == RA2D)) ? 1 : 0;
        pend = (PCSrcD || PCSrcE || PCSrcM) ? 1 : 0;
        if (mstall != 0) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
        end else begin
            e.sf = (ld != 0 || pend != 0) ? 1 : 0;
            e.sd = ld;
            e.fd = (pend != 0 || PCSrcW || BranchTakenE) ? 1 : 0;
            e.fe = (ld != 0 || BranchTakenE) ? 1 : 0;
        end
        return e;
    endfunction

    // Inputs are set just after a rising edge; outputs are checked on the falling edge.
    task automatic step();
        exp_t ea, eb;
        @(negedge clk);
        ea = model(4, ph_a);
        eb = model(2, ph_b);
        chk("A.ForwardAE", int'(a_fa), ea.fa);   chk("A.ForwardBE", int'(a_fb), ea.fb);
        chk("A.StallF", int'(a_sf), ea.sf);      chk("A.StallD", int'(a_sd), ea.sd);
        chk("A.StallE", int'(a_se), ea.se);      chk("A.FlushD", int'(a_fd), ea.fd);
        chk("A.FlushE", int'(a_fe), ea.fe);      chk("A.FlushM", int'(a_fm), ea.fm);
        chk("A.MulBusy", int'(a_busy), ea.busy); chk("A.MulDone", int'(a_done), ea.done);
        chk("A.StallCycles", int'(a_sc), sc_a);
        chk("B.ForwardAE", int'(b_fa), eb.fa);   chk("B.ForwardBE", int'(b_fb), eb.fb);
        chk("B.StallF", int'(b_sf), eb.sf);      chk("B.StallD", int'(b_sd), eb.sd);
        chk("B.StallE", int'(b_se), eb.se);      chk("B.FlushD", int'(b_fd), eb.fd);
        chk("B.FlushE", int'(b_fe), eb.fe);      chk("B.FlushM", int'(b_fm), eb.fm);
        chk("B.MulBusy", int'(b_busy), eb.busy); chk("B.MulDone", int'(b_done), eb.done);
        chk("B.StallCycles", int'(b_sc), sc_b);
        @(posedge clk);
        ph_a = ea.nph;
        ph_b = eb.nph;
        if (reset) begin
            sc_a = 0; sc_b = 0;
        end else begin
            if (ea.sf != 0 && sc_a < 15)    sc_a++;
            if (eb.sf != 0 && sc_b < 65535) sc_b++;
        end
        cyc++;
        #1;
    endtask

    task automatic quiet();
        {RA1D, RA2D, RA1E, RA2E} = '0;
        WA3E = 4'd9; WA3M = 4'd9; WA3W = 4'd9;
        {RegWriteM, RegWriteW, MemToRegE} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulE} = '0;
    endtask

    function automatic logic [3:0] pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        quiet();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        // Forwarding priority and the PC exclusion.
        RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3;
        #3 chk("fwd_m", int'(a_fa), 2);
        step();
        RegWriteM = 0;
        #3 chk("fwd_w", int'(a_fa), 1);
        step();
        RA1E = 15;
        #3 chk("fwd_pc", int'(a_fa), 0);
        step();
        quiet();

        // Load-use stall lasts exactly one cycle.
        MemToRegE = 1; WA3E = 5; RA2D = 5;
        #3 chk("ldr_stallf", int'(a_sf), 1);
        chk("ldr_flushd", int'(a_fd), 0);
        step();
        quiet();
        step();

        BranchTakenE = 1;
        #3 chk("br_flushe", int'(a_fe), 1);
        chk("br_stallf", int'(a_sf), 0);
        step();
        quiet();
        PCSrcD = 1; step();
        PCSrcD = 0; PCSrcE = 1; step();
        PCSrcE = 0; PCSrcM = 1; step();
        PCSrcM = 0; PCSrcW = 1;
        #3 chk("pcw_stallf", int'(a_sf), 0);
        chk("pcw_flushd", int'(a_fd), 1);
        step();
        quiet();

        // Multiply held in E: MUL_LAT=4 stalls 3 cycles then finishes; MUL_LAT=2 stalls once.
        MulE = 1;
        for (int i = 0; i < 4; i++) begin
            #3 chk("mul4_stall", int'(a_se), (i < 3) ? 1 : 0);
            chk("mul4_done", int'(a_done), (i == 3) ? 1 : 0);
            if (i < 2) chk("mul2_done", int'(b_done), i);
            step();
        end
        MulE = 0;
        step();

        // Reset one cycle into a multiply aborts it.
        MulE = 1; step();
        MulE = 0; reset = 1;
        #3 chk("rst_flushm", int'(a_fm), 1);
        chk("rst_done", int'(a_done), 0);
        step();
        reset = 0;
        #3 chk("rst_count", int'(a_sc), 0);
        step();
        step();

        // 20 cycles of load-use stall saturate the 4-bit counter.
        MemToRegE = 1; WA3E = 5; RA1D = 5;
        for (int i = 0; i < 20; i++) step();
        #3 chk("sat_count", int'(a_sc), 15);
        step();
        quiet();

        for (int i = 0; i < 800; i++) begin
            reset        = ($urandom_range(0, 59) == 0);
            RA1D = pick_reg(); RA2D = pick_reg(); RA1E = pick_reg(); RA2E = pick_reg();
            WA3E = pick_reg(); WA3M = pick_reg(); WA3W = pick_reg();
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            PCSrcD       = ($urandom_range(0, 7) == 0);
            PCSrcE       = ($urandom_range(0, 7) == 0);
            PCSrcM       = ($urandom_range(0, 7) == 0);
            PCSrcW       = ($urandom_range(0, 7) == 0);
            MulE         = ($urandom_range(0, 5) == 0);
            BranchTakenE = MulE ? 1'b0 : ($urandom_range(0, 7) == 0);
            MemToRegE    = MulE ? 1'b0 : ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
